// File: rtl/pill_line_pkg.sv
// Shared encodings for the pill line plant model: FSM states, jitter LFSR, count limits.
// No logic beyond a pure LFSR step function.
package pill_line_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FEED   = 2'd1,
        ST_MOVE   = 2'd2,
        ST_JAMMED = 2'd3
    } line_state_t;

    localparam logic [7:0] LFSR_SEED        = 8'hA5;
    // Taps x^8 + x^6 + x^5 + x^4 mapped onto bit indices 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS        = 8'b1011_1000;
    localparam logic [9:0] PILL_COUNT_MAX   = 10'd999;
    localparam logic [6:0] BOTTLE_COUNT_MAX = 7'd99;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pill_line_emulator_ms_timer.sv
// Loadable down-counter in clock cycles with a zero flag; load wins over run.
// Counting stops at zero and holds its value while run is low.
module ms_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pill_line_emulator.sv
// Bottling-line plant model: pill pulses while feeding, bottle moves on request, hopper stock.
// All outputs registered; PILL_JITTER_EN adds LFSR jitter to the pill period.
module pill_line_emulator
    import pill_line_pkg::*;
#(
    parameter int PILL_PERIOD_MS = 1000,
    parameter int PULSE_MS       = 20,
    parameter int BOTTLE_MOVE_MS = 1500,
    parameter int HOPPER_CAP     = 200,
    parameter int REFILL_PILLS   = 50
) (
    input  logic       clk_1khz,
    input  logic       clr,
    input  logic       feed_en,
    input  logic       bottle_req,
    input  logic       jam_inject,
    input  logic       drain_inject,
    input  logic       refill,
    output logic       hopper_level,
    output logic       conveyor_ok,
    output logic       bottle_in_place,
    output logic [7:0] pills_left,
    output logic [9:0] pill_count,
    output logic [6:0] bottle_count
);

    localparam int PW = $clog2(PILL_PERIOD_MS + 16) + 1;
    localparam int MW = $clog2(BOTTLE_MOVE_MS) + 1;
    localparam int CW = $clog2(PULSE_MS + 1);

    line_state_t   state;
    logic          req_q;
    logic          refill_q;
    logic [CW-1:0] pulse_cnt;
    logic          req_edge;
    logic          refill_edge;
    logic          in_move;
    logic          dispense;
    logic          period_zero;
    logic          move_zero;
    logic          load_period;
    logic          load_move;
    logic          run_move;
    logic [PW-1:0] reload_val;
    logic [8:0]    stock_sum;
    logic [7:0]    stock_next;

    assign req_edge    = bottle_req & ~req_q;
    assign refill_edge = refill & ~refill_q;
    assign in_move     = (state == ST_MOVE) || (state == ST_JAMMED);
    assign dispense    = (state == ST_FEED) && feed_en && period_zero && (pills_left != 8'd0);
    assign load_period = ((state == ST_IDLE) && !req_edge && feed_en && bottle_in_place)
                      || ((state == ST_FEED) && period_zero);
    assign load_move   = req_edge && !in_move;
    // Jam freezes the move timer; the cycle jam drops already counts again.
    assign run_move    = in_move && !jam_inject;

`ifdef PILL_JITTER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            lfsr <= LFSR_SEED;
        end else if (dispense) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign reload_val = PW'(PILL_PERIOD_MS - 1) + PW'(lfsr[3:0]);
`else
    assign reload_val = PW'(PILL_PERIOD_MS - 1);
`endif

    ms_timer #(.W(PW)) u_period_timer (
        .clk      (clk_1khz),
        .clr      (clr),
        .load     (load_period),
        .load_val (reload_val),
        .run      (state == ST_FEED),
        .zero     (period_zero)
    );

    ms_timer #(.W(MW)) u_move_timer (
        .clk      (clk_1khz),
        .clr      (clr),
        .load     (load_move),
        .load_val (MW'(BOTTLE_MOVE_MS - 1)),
        .run      (run_move),
        .zero     (move_zero)
    );

    // Stock math runs 9 bits wide so refill overshoot saturates instead of wrapping.
    always_comb begin
        stock_sum = {1'b0, pills_left}
                  + (refill_edge ? 9'(REFILL_PILLS) : 9'd0)
                  - (dispense ? 9'd1 : 9'd0);
        if (drain_inject) begin
            stock_next = 8'd0;
        end else if (stock_sum > 9'(HOPPER_CAP)) begin
            stock_next = 8'(HOPPER_CAP);
        end else begin
            stock_next = stock_sum[7:0];
        end
    end

    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            state           <= ST_IDLE;
            req_q           <= 1'b0;
            refill_q        <= 1'b0;
            pulse_cnt       <= '0;
            hopper_level    <= 1'b0;
            conveyor_ok     <= 1'b1;
            bottle_in_place <= 1'b1;
            pills_left      <= 8'(HOPPER_CAP);
            pill_count      <= 10'd0;
            bottle_count    <= 7'd0;
        end else begin
            req_q       <= bottle_req;
            refill_q    <= refill;
            conveyor_ok <= ~jam_inject;
            pills_left  <= stock_next;

            // Pulse stretcher runs independently of the FSM so a pulse always completes.
            if (dispense) begin
                hopper_level <= 1'b1;
                pulse_cnt    <= CW'(PULSE_MS - 1);
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - 1'b1;
            end else begin
                hopper_level <= 1'b0;
            end

            if (dispense && (pill_count != PILL_COUNT_MAX)) begin
                pill_count <= pill_count + 10'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (req_edge) begin
                        state           <= ST_MOVE;
                        bottle_in_place <= 1'b0;
                    end else if (feed_en && bottle_in_place) begin
                        state <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (req_edge) begin
                        state           <= ST_MOVE;
                        bottle_in_place <= 1'b0;
                    end else if (!feed_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (jam_inject) begin
                        state <= ST_JAMMED;
                    end else if (move_zero) begin
                        state           <= ST_IDLE;
                        bottle_in_place <= 1'b1;
                        pill_count      <= 10'd0;
                        bottle_count    <= (bottle_count == BOTTLE_COUNT_MAX) ? 7'd0
                                                                             : bottle_count + 7'd1;
                    end else begin
                        state <= ST_MOVE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pill_line_emulator.sv
// Bench for pill_line_emulator: directed scenarios plus random traffic against a reference model.
// Honours PILL_JITTER_EN when defined for the build.
module tb_pill_line_emulator;

    localparam int P     = 10;
    localparam int W     = 2;
    localparam int M     = 5;
    localparam int CAP   = 8;
    localparam int RFL   = 3;
`ifdef PILL_JITTER_EN
    localparam int JIT0  = 5;
`else
    localparam int JIT0  = 0;
`endif

    localparam int S_IDLE = 0;
    localparam int S_FEED = 1;
    localparam int S_MOVE = 2;
    localparam int S_JAM  = 3;

    logic       clk_1khz = 1'b0;
    logic       clr = 1'b1;
    logic       feed_en = 1'b0;
    logic       bottle_req = 1'b0;
    logic       jam_inject = 1'b0;
    logic       drain_inject = 1'b0;
    logic       refill = 1'b0;
    logic       hopper_level;
    logic       conveyor_ok;
    logic       bottle_in_place;
    logic [7:0] pills_left;
    logic [9:0] pill_count;
    logic [6:0] bottle_count;

    int checks = 0;
    int errors = 0;

    pill_line_emulator #(
        .PILL_PERIOD_MS (P),
        .PULSE_MS       (W),
        .BOTTLE_MOVE_MS (M),
        .HOPPER_CAP     (CAP),
        .REFILL_PILLS   (RFL)
    ) dut (
        .clk_1khz        (clk_1khz),
        .clr             (clr),
        .feed_en         (feed_en),
        .bottle_req      (bottle_req),
        .jam_inject      (jam_inject),
        .drain_inject    (drain_inject),
        .refill          (refill),
        .hopper_level    (hopper_level),
        .conveyor_ok     (conveyor_ok),
        .bottle_in_place (bottle_in_place),
        .pills_left      (pills_left),
        .pill_count      (pill_count),
        .bottle_count    (bottle_count)
    );

    always #5 clk_1khz = ~clk_1khz;

    // Reference model: line state as plain integers, pulse as "high cycles remaining".
    int m_state, m_period, m_move, m_hi_left, m_stock, m_pills, m_bottles, m_lfsr;
    bit m_ok, m_bip, m_req_q, m_ref_q;

    function automatic int period_reload(input int l);
`ifdef PILL_JITTER_EN
        return P - 1 + (l % 16);
`else
        return P - 1 + 0 * l;
`endif
    endfunction

    function automatic int lfsr_adv(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_period = 0; m_move = 0; m_hi_left = 0;
        m_stock = CAP; m_pills = 0; m_bottles = 0; m_lfsr = 8'hA5;
        m_ok = 1; m_bip = 1; m_req_q = 0; m_ref_q = 0;
    endtask

    task automatic model_step();
        bit req_edge, ref_edge, disp;
        int stock_next;
        if (clr) begin
            model_reset();
            return;
        end
        req_edge = bottle_req && !m_req_q;
        ref_edge = refill && !m_ref_q;
        disp     = (m_state == S_FEED) && feed_en && (m_period == 0) && (m_stock > 0);

        if (disp) m_hi_left = W;
        else if (m_hi_left > 0) m_hi_left--;

        stock_next = m_stock + (ref_edge ? RFL : 0) - (disp ? 1 : 0);
        if (stock_next > CAP) stock_next = CAP;
        if (drain_inject) stock_next = 0;

        if (disp && m_pills < 999) m_pills++;

        case (m_state)
            S_IDLE: begin
                if (req_edge) begin
                    m_state = S_MOVE; m_move = M - 1; m_bip = 0;
                end else if (feed_en && m_bip) begin
                    m_state = S_FEED; m_period = period_reload(m_lfsr);
                end
            end
            S_FEED: begin
                m_period = (m_period == 0) ? period_reload(m_lfsr) : m_period - 1;
                if (req_edge) begin
                    m_state = S_MOVE; m_move = M - 1; m_bip = 0;
                end else if (!feed_en) begin
                    m_state = S_IDLE;
                end
            end
            default: begin
                if (jam_inject) begin
                    m_state = S_JAM;
                end else if (m_move == 0) begin
                    m_state = S_IDLE; m_bip = 1; m_pills = 0;
                    m_bottles = (m_bottles + 1) % 100;
                end else begin
                    m_move--; m_state = S_MOVE;
                end
            end
        endcase

        if (disp) m_lfsr = lfsr_adv(m_lfsr);
        m_stock = stock_next;
        m_ok    = !jam_inject;
        m_req_q = bottle_req;
        m_ref_q = refill;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1khz);
        model_step();
        #1;
        check("hopper_level", 32'(hopper_level), 32'(m_hi_left > 0));
        check("conveyor_ok", 32'(conveyor_ok), 32'(m_ok));
        check("bottle_in_place", 32'(bottle_in_place), 32'(m_bip));
        check("pills_left", 32'(pills_left), m_stock);
        check("pill_count", 32'(pill_count), m_pills);
        check("bottle_count", 32'(bottle_count), m_bottles);
    endtask

    task automatic wait_rise(input int limit, output int n);
        logic pv;
        bit   found;
        n = 0;
        found = 0;
        while (!found && n < limit) begin
            pv = hopper_level;
            tick();
            n++;
            found = hopper_level && !pv;
        end
        check("rise_seen", 32'(found), 1);
    endtask

    task automatic do_move();
        bottle_req = 1;
        tick();
        bottle_req = 0;
        repeat (6) tick();
    endtask

    int   rises, highs, last, n, lowb, lowok;
    logic prev;

    initial begin
        model_reset();
        repeat (2) tick();
        clr = 0;
        check("rst_hopper", 32'(hopper_level), 0);
        check("rst_conv", 32'(conveyor_ok), 1);
        check("rst_bip", 32'(bottle_in_place), 1);
        check("rst_pills", 32'(pills_left), CAP);
        check("rst_pc", 32'(pill_count), 0);
        check("rst_bc", 32'(bottle_count), 0);

        // Feed 35 cycles.
        feed_en = 1; rises = 0; highs = 0; last = -1;
        for (int i = 0; i < 35; i++) begin
            prev = hopper_level;
            tick();
            if (hopper_level && !prev) begin
`ifdef PILL_JITTER_EN
                if (last >= 0) check("spacing_range", 32'((i - last) >= 10 && (i - last) <= 25), 1);
`else
                if (last >= 0) check("pulse_spacing", i - last, 10);
`endif
                last = i; rises++;
            end
            if (hopper_level) highs++;
        end
`ifndef PILL_JITTER_EN
        check("feed35_pulses", rises, 3);
        check("feed35_high", highs, 6);
        check("feed35_pills", 32'(pills_left), 5);
        check("feed35_pc", 32'(pill_count), 3);
`endif

        // Bottle request while a pulse is high.
        wait_rise(40, n);
        bottle_req = 1; feed_en = 0; highs = 1; lowb = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (hopper_level) highs++;
            if (!bottle_in_place) lowb++;
        end
        check("req_pulse_width", highs, 2);
        check("move_low", lowb, 5);
        check("move_pc", 32'(pill_count), 0);
        check("move_bc", 32'(bottle_count), 1);

        // Jam for 4 cycles mid-move.
        bottle_req = 0;
        tick();
        bottle_req = 1; lowb = 0; lowok = 0;
        for (int k = 0; k < 20; k++) begin
            jam_inject = (k >= 3 && k <= 6);
            tick();
            if (!bottle_in_place) lowb++;
            if (!conveyor_ok) lowok++;
        end
        jam_inject = 0; bottle_req = 0;
        check("jam_bip_low", lowb, 9);
        check("jam_ok_low", lowok, 4);
        check("jam_bc", 32'(bottle_count), 2);

        // Drain then starve.
        drain_inject = 1;
        tick();
        drain_inject = 0;
        check("drain_pills", 32'(pills_left), 0);
        feed_en = 1; rises = 0;
        for (int i = 0; i < 30; i++) begin
            prev = hopper_level;
            tick();
            if (hopper_level && !prev) rises++;
        end
        check("starve_pulses", rises, 0);
        feed_en = 0;
        for (int r = 0; r < 3; r++) begin
            refill = 1; tick();
            refill = 0; tick();
        end
        check("refill_sat", 32'(pills_left), CAP);

        // Refill on the same edge as a dispense at stock 7.
        feed_en = 1;
        wait_rise(40, n);
        check("stock_7", 32'(pills_left), 7);
        for (int i = 0; i < 40 && m_period != 0; i++) tick();
        refill = 1;
        tick();
        refill = 0;
        check("refill_disp_sat", 32'(pills_left), CAP);
        check("refill_disp_pulse", 32'(hopper_level), 1);
        feed_en = 0;
        repeat (3) tick();

        // Bottle counter wrap.
        for (int i = 0; i < 120 && m_bottles != 99; i++) do_move();
        check("bc_99", 32'(bottle_count), 99);
        do_move();
        check("bc_wrap", 32'(bottle_count), 0);

        // Reset mid-pulse.
        feed_en = 1;
        wait_rise(40, n);
        clr = 1;
        tick();
        clr = 0;
        check("clr_hopper", 32'(hopper_level), 0);
        check("clr_pills", 32'(pills_left), CAP);
        check("clr_pc", 32'(pill_count), 0);
        check("clr_bip", 32'(bottle_in_place), 1);
        wait_rise(40, n);
        check("clr_first_pulse", n, 11 + JIT0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 20 == 0) feed_en = ~feed_en;
            if ($urandom % 15 == 0) jam_inject = ~jam_inject;
            bottle_req   = ($urandom % 12 == 0);
            refill       = ($urandom % 10 == 0);
            drain_inject = ($urandom % 80 == 0);
            clr          = ($urandom % 400 == 0);
            tick();
        end
        clr = 0; jam_inject = 0; bottle_req = 0; refill = 0; drain_inject = 0; feed_en = 0;
        tick();

`ifdef PILL_JITTER_EN
        begin
            int sp1[$];
            int sp2[$];
            for (int run = 0; run < 2; run++) begin
                clr = 1; tick(); clr = 0;
                feed_en = 1; last = -1;
                for (int i = 0; i < 220; i++) begin
                    prev = hopper_level;
                    tick();
                    if (hopper_level && !prev) begin
                        if (last >= 0) begin
                            if (run == 0) sp1.push_back(i - last);
                            else sp2.push_back(i - last);
                        end
                        last = i;
                    end
                end
                feed_en = 0;
            end
            check("jit_nonempty", 32'(sp1.size() > 0), 1);
            check("jit_count", sp2.size(), sp1.size());
            foreach (sp1[i]) begin
                check("jit_range", 32'(sp1[i] >= 10 && sp1[i] <= 25), 1);
                if (i < sp2.size()) check("jit_repeat", sp2[i], sp1[i]);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
